// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// default address map and the access-legality check used at request accept.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] DATA_BASE_DEF = 32'h0000_0800;
  localparam logic [31:0] ADDR_TOP_DEF  = 32'h0000_0FFC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MODIFY = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Misalignment, illegal width (unsigned widths are load-only), range and write protection.
  function automatic logic access_fault(input logic        store,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input logic [31:0] data_base,
                                        input logic [31:0] addr_top);
    logic f;
    f = 1'b0;
    case (f3)
      F3_B:    f = 1'b0;
      F3_H:    f = addr[0];
      F3_W:    f = (addr[1:0] != 2'b00);
      F3_BU:   f = store;
      F3_HU:   f = store | addr[0];
      default: f = 1'b1;
    endcase
    f = f | (addr > (addr_top + 32'd3)) | (store & (addr < data_base));
    return f;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, and merges sub-word
// store data into a read word for the read-modify-write path.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load path: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    load_data_o = 32'h0000_0000;
    case (lane_i)
      2'b00:   byte_s = word_i[7:0];
      2'b01:   byte_s = word_i[15:8];
      2'b10:   byte_s = word_i[23:16];
      2'b11:   byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
      F3_W:    load_data_o = word_i;
      F3_BU:   load_data_o = {24'h00_0000, byte_s};
      F3_HU:   load_data_o = {16'h0000, half_s};
      default: load_data_o = 32'h0000_0000;
    endcase
  end

  // Store path: overwrite only the addressed byte/half of the read word.
  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (lane_i)
          2'b00:   merged_o[7:0]   = wdata_i[7:0];
          2'b01:   merged_o[15:8]  = wdata_i[7:0];
          2'b10:   merged_o[23:16] = wdata_i[7:0];
          2'b11:   merged_o[31:24] = wdata_i[7:0];
          default: merged_o        = word_i;
        endcase
      end
      F3_H: begin
        if (lane_i[1]) begin
          merged_o[31:16] = wdata_i;
        end else begin
          merged_o[15:0] = wdata_i;
        end
      end
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-access master for a single-port word memory without byte enables;
// sub-word stores are performed as read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = DATA_BASE_DEF,
  parameter logic [31:0] ADDR_TOP  = ADDR_TOP_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  load_store_unit_if.slave core,
  output logic [31:0]      mem_address_o,
  output logic [31:0]      mem_data_out_o,
  input  logic [31:0]      mem_data_in_i,
  output logic             mem_we_o
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic        fault_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] mem_address_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_fault_q;
  logic        fault_d;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  assign fault_d = access_fault(core.req_store, core.req_funct3, core.req_addr,
                                DATA_BASE, ADDR_TOP);

  lsu_lane_align u_lane_align (
    .word_i      (mem_data_in_i),
    .lane_i      (lane_q),
    .funct3_i    (funct3_q),
    .wdata_i     (wdata_q[15:0]),
    .load_data_o (load_data_s),
    .merged_o    (merged_s)
  );

  // Next-state decode; only sub-word stores without a fault take the MODIFY detour.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (fault_q || !store_q || (funct3_q == F3_W)) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_MODIFY;
        end
      end
      ST_MODIFY: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state, request capture and registered response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      lane_q        <= 2'b00;
      funct3_q      <= 3'b000;
      store_q       <= 1'b0;
      fault_q       <= 1'b0;
      wdata_q       <= 32'h0000_0000;
      merge_q       <= 32'h0000_0000;
      mem_address_q <= 32'h0000_0000;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0000_0000;
      resp_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (core.req_valid) begin
            lane_q        <= core.req_addr[1:0];
            funct3_q      <= core.req_funct3;
            store_q       <= core.req_store;
            wdata_q       <= core.req_wdata;
            fault_q       <= fault_d;
            mem_address_q <= {core.req_addr[31:2], 2'b00};
          end
        end
        ST_ACCESS: begin
          merge_q <= merged_s;
          if (state_d == ST_RESP) begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= fault_q;
            resp_rdata_q <= (fault_q || store_q) ? 32'h0000_0000 : load_data_s;
          end
        end
        ST_MODIFY: begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
        end
        default: begin
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Write enable depends on registers only, so an async reset kills it at once.
  assign mem_we_o = (state_q == ST_MODIFY) ||
                    ((state_q == ST_ACCESS) && store_q && !fault_q && (funct3_q == F3_W));

  assign mem_data_out_o  = (state_q == ST_MODIFY) ? merge_q : wdata_q;
  assign mem_address_o   = mem_address_q;
  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = resp_valid_q;
  assign core.resp_rdata = resp_rdata_q;
  assign core.resp_fault = resp_fault_q;

endmodule
